mem_responder: RTL

- Responder end of the CPU data/instruction memory bus: 256x8 byte store plus one memory-mapped output register.
- Serves a single initiator over a four-phase req/ready handshake, with a fixed number of wait states per parameter.
- Replaces the zero-latency memory model, so the CPU can later run against realistic memory timing, and it provides an RTL output port.

---
 rtl/mem_responder_if.sv | 23 ++
 rtl/mem_responder.sv | 104 ++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// Memory bus between one initiator and the responder.
// Four-phase req/ready handshake; rdata valid while ready.
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ready;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ready, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rdata
  );
endinterface

// File: rtl/mem_responder.sv
// Byte-store responder with one memory-mapped output register.
// Fixed wait states per access, registered outputs.
module mem_responder #(
  parameter int                  ADDR_WIDTH  = 8,
  parameter int                  DATA_WIDTH  = 8,
  parameter int                  WAIT_CYCLES = 2,
  parameter logic [ADDR_WIDTH-1:0] IO_ADDR   = '1,
  parameter string               INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_responder_if.slave        bus,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic [7:0]            access_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  ready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  is_io;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign is_io     = (addr_q == IO_ADDR);
  assign bus.ready = ready;
  assign bus.rdata = rdata;

  // Array write port: only a committed, non-IO write lands here.
  always_ff @(posedge clk) begin
    if (state == S_ACCESS && we_q && !is_io)
      mem[addr_q] <= wdata_q;
  end

  // Handshake FSM. WAIT spends one decode cycle plus
  // WAIT_CYCLES cycles, so ready rises WAIT_CYCLES+2 edges
  // after the accepting edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ready        <= 1'b0;
      rdata        <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      access_count <= '0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.req) begin
            we_q    <= bus.we;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            cnt     <= WAIT_CNT;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_ACCESS;
          else             cnt   <= cnt - 4'd1;
        end
        S_ACCESS: begin
          if (we_q) begin
            if (is_io) begin
              out_data  <= wdata_q;
              out_valid <= 1'b1;
            end
          end else begin
            rdata <= is_io ? out_data : mem[addr_q];
          end
          access_count <= access_count + 8'd1;
          ready        <= 1'b1;
          state        <= S_RESP;
        end
        S_RESP: begin
          if (!bus.req) begin
            ready <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
